// File: rtl/alu_multicycle.sv
`timescale 1ns/1ps
// alu_multicycle: parametrised multi-cycle ALU with a valid/ready request side
// and a held result side. Single-cycle ops finish in one cycle; MUL/DIV
// iterate WIDTH steps when built with `define ALU_MULDIV_EN. Without that
// macro the MUL/DIV opcodes are treated as illegal.
//
// Handshake: a request is accepted on a clock edge where in_valid && in_ready
// (in_ready is high only in IDLE). A result is offered while out_valid is high
// (only in DONE) and is taken on the edge where out_valid && out_ready; until
// then result, result_hi, flags and err are held stable.
module alu_multicycle #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             out_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_ROL = 4'h8;
  localparam logic [3:0] OP_ROR = 4'h9;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_DIV = 4'hB;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic [3:0]       flags_q;
  logic             err_q;

  // Single-cycle datapath
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] c_res;
  logic [WIDTH-1:0] c_hi;
  logic             c_c;
  logic             c_v;
  logic             c_err;
  logic             c_legal;
  logic [3:0]       c_flags;
  logic             go_busy;

  assign add_w = {1'b0, operand_a} + {1'b0, operand_b};
  assign sub_w = {1'b0, operand_a} - {1'b0, operand_b};

`ifdef ALU_MULDIV_EN
  // Iterative MUL/DIV working state; acc_hi/acc_lo are {hi,lo} for MUL and
  // {remainder,quotient} for DIV, m_q is the multiplicand or divisor.
  logic [CW-1:0]    cnt;
  logic             is_div_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // One shift-add or restoring-subtract step of the iterative unit
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : '0);
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    step_hi  = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end
`endif

  // Decode the request and compute single-cycle results, errors and flags
  always_comb begin
    c_res   = '0;
    c_hi    = '0;
    c_c     = 1'b0;
    c_v     = 1'b0;
    c_err   = 1'b0;
    c_legal = 1'b1;
    go_busy = 1'b0;
    case (op)
      OP_ADD: begin
        c_res = add_w[WIDTH-1:0];
        c_c   = add_w[WIDTH];
        c_v   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                (add_w[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        c_res = sub_w[WIDTH-1:0];
        c_c   = sub_w[WIDTH];
        c_v   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                (sub_w[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_AND: c_res = operand_a & operand_b;
      OP_OR:  c_res = operand_a | operand_b;
      OP_XOR: c_res = operand_a ^ operand_b;
      OP_NOT: c_res = ~operand_a;
      OP_SHL: begin
        c_res = {operand_a[WIDTH-2:0], 1'b0};
        c_c   = operand_a[WIDTH-1];
      end
      OP_SHR: begin
        c_res = {1'b0, operand_a[WIDTH-1:1]};
        c_c   = operand_a[0];
      end
      OP_ROL: c_res = {operand_a[WIDTH-2:0], operand_a[WIDTH-1]};
      OP_ROR: c_res = {operand_a[0], operand_a[WIDTH-1:1]};
`ifdef ALU_MULDIV_EN
      OP_MUL: go_busy = 1'b1;
      OP_DIV: begin
        if (operand_b == '0) begin
          // Divide by zero resolves immediately with a saturated quotient
          c_res = '1;
          c_hi  = operand_a;
          c_err = 1'b1;
        end else begin
          go_busy = 1'b1;
        end
      end
`endif
      default: begin
        c_legal = 1'b0;
        c_err   = 1'b1;
      end
    endcase
    c_flags = c_legal ? {c_res[WIDTH-1], (c_res == '0), c_c, c_v} : 4'b0000;
  end

  // Control FSM and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt      <= '0;
      is_div_q <= 1'b0;
      m_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef ALU_MULDIV_EN
            if (go_busy) begin
              is_div_q <= (op == OP_DIV);
              m_q      <= (op == OP_DIV) ? operand_b : operand_a;
              acc_hi   <= '0;
              acc_lo   <= (op == OP_DIV) ? operand_a : operand_b;
              cnt      <= '0;
              state    <= S_BUSY;
            end else
`endif
            begin
              res_q   <= c_res;
              hi_q    <= c_hi;
              flags_q <= c_flags;
              err_q   <= c_err;
              state   <= S_DONE;
            end
          end
        end
`ifdef ALU_MULDIV_EN
        S_BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            res_q   <= step_lo;
            hi_q    <= step_hi;
            flags_q <= {step_lo[WIDTH-1], (step_lo == '0), 1'b0,
                        (!is_div_q && (step_hi != '0))};
            err_q   <= 1'b0;
            state   <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = out_en ? res_q : '0;
  assign result_hi = out_en ? hi_q  : '0;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule
